squeeze_out_stage: RTL and testbench

//  Parametrised successor of the single-block output stage: final pipeline stage after the Keccak permutation.

---
 rtl/squeeze_out_stage.sv | 211 +++++++++++++++++++++
 tb/tb_squeeze_out_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/squeeze_out_stage.sv
// Squeeze output stage: buffers up to DEPTH rate blocks from the permutation,
// serialises the head block into W-bit words under valid/ready, tracks the
// requested output length, flags the last word and drops surplus words.
// Optional feature: define SQUEEZE_STALL_CNT_EN to add stall_cnt_out, a
// saturating count of cycles with valid_out && !ready_in.
module squeeze_out_stage #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1343:0]    block_in,
  input  logic             block_we_in,
  input  logic [1:0]       operation_mode,
  input  logic [LEN_W-1:0] out_len_in,
  output logic             block_ready_out,
  output logic [W-1:0]     data_out,
  output logic             valid_out,
  output logic             last_out,
  input  logic             ready_in,
  output logic             req_done_out
`ifdef SQUEEZE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt_out
`endif
);

  localparam int unsigned RateMax = 1344;
  localparam int unsigned MaxWpb  = RateMax / W;
  localparam int unsigned IdxW    = $clog2(MaxWpb);
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StEmit} head_state_e;

  // Block FIFO storage
  logic [RateMax-1:0] mem_q  [DEPTH];
  logic [1:0]         mode_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             req_active_q, req_active_d;
  logic             req_done_q, req_done_d;
  head_state_e      state_q, state_d;

  logic [RateMax-1:0] head_blk;
  logic [1:0]         head_mode;
  logic [IdxW-1:0]    last_idx;
  logic [LEN_W-1:0]   new_len;
  logic               full, wr_acc, hs, last_hs, head_end, orphan, free, start;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  assign head_blk  = mem_q[rd_ptr_q];
  assign head_mode = mode_q[rd_ptr_q];

  // Index of the final word of the head block, from its own latched mode
  always_comb begin
    last_idx = '0;
    case (head_mode)
      2'b00:        last_idx = IdxW'(1344 / W - 1);
      2'b01, 2'b10: last_idx = IdxW'(1088 / W - 1);
      default:      last_idx = IdxW'(576 / W - 1);
    endcase
  end

  // Length latched at request start; SHA3 modes have a fixed digest size
  always_comb begin
    new_len = '0;
    case (operation_mode)
      2'b00, 2'b01: new_len = (out_len_in == '0) ? LEN_W'(1) : out_len_in;
      2'b10:        new_len = LEN_W'(256 / W);
      default:      new_len = LEN_W'(512 / W);
    endcase
  end

  assign full            = (count_q == CntW'(DEPTH));
  assign block_ready_out = !full;
  assign valid_out       = (state_q == StEmit);
  assign data_out        = valid_out ? head_blk[32'(idx_q) * W +: W] : '0;
  assign last_out        = valid_out && (rem_q == LEN_W'(1));
  assign req_done_out    = req_done_q;

  assign hs       = valid_out && ready_in;
  assign last_hs  = hs && (rem_q == LEN_W'(1));
  assign head_end = hs && ((idx_q == last_idx) || (rem_q == LEN_W'(1)));
  // A block left in the FIFO with no request to serve it is dropped silently
  assign orphan   = (count_q != '0) && !req_active_q;
  assign free     = head_end || orphan;
  assign wr_acc   = block_we_in && !full;
  // A write in the cycle the last word leaves already belongs to the next request
  assign start    = wr_acc && (!req_active_q || last_hs);

  // Next-state for FIFO bookkeeping, word index and request tracking
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    req_active_d = req_active_q;
    req_done_d   = last_hs;

    if (wr_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (free) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (wr_acc && !free) begin
      count_d = count_q + CntW'(1);
    end else if (!wr_acc && free) begin
      count_d = count_q - CntW'(1);
    end

    if (free) begin
      idx_d = '0;
    end else if (hs) begin
      idx_d = idx_q + IdxW'(1);
    end

    if (start) begin
      rem_d        = new_len;
      req_active_d = 1'b1;
    end else if (hs) begin
      rem_d = rem_q - LEN_W'(1);
      if (last_hs) begin
        req_active_d = 1'b0;
      end
    end
  end

  // Head FSM: emit whenever a block is buffered for an active request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if ((count_d != '0) && req_active_d) state_d = StEmit;
      StEmit: if ((count_d == '0) || !req_active_d) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      rem_q        <= '0;
      req_active_q <= 1'b0;
      req_done_q   <= 1'b0;
      state_q      <= StIdle;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      rem_q        <= rem_d;
      req_active_q <= req_active_d;
      req_done_q   <= req_done_d;
      state_q      <= state_d;
    end
  end

  // Block storage: block and its mode captured together on an accepted write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[wr_ptr_q]  <= block_in;
      mode_q[wr_ptr_q] <= operation_mode;
    end
  end

`ifdef SQUEEZE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled output cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_out && !ready_in && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_squeeze_out_stage.sv
// Scoreboard bench for squeeze_out_stage (W=64, DEPTH=2). Requests are
// planned from the rate/length rules, expected words queued, and a monitor
// compares every presented word against the queue head.
module tb_squeeze_out_stage;

  localparam int unsigned Rate = 1344;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [Rate-1:0] block_in = '0;
  logic            block_we_in = 1'b0;
  logic [1:0]      operation_mode = '0;
  logic [31:0]     out_len_in = '0;
  logic            block_ready_out;
  logic [63:0]     data_out;
  logic            valid_out;
  logic            last_out;
  logic            ready_in = 1'b0;
  logic            req_done_out;
`ifdef SQUEEZE_STALL_CNT_EN
  logic [31:0]     stall_cnt_out;
`endif

  squeeze_out_stage #(.W(64), .DEPTH(2), .LEN_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .block_in        (block_in),
    .block_we_in     (block_we_in),
    .operation_mode  (operation_mode),
    .out_len_in      (out_len_in),
    .block_ready_out (block_ready_out),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .last_out        (last_out),
    .ready_in        (ready_in),
    .req_done_out    (req_done_out)
`ifdef SQUEEZE_STALL_CNT_EN
    ,
    .stall_cnt_out   (stall_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t            exp_q[$];
  logic [Rate-1:0] plan_blk[$];
  logic [1:0]      plan_mode[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  bit              rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Words per rate block for W=64
  function automatic int unsigned wpb(input logic [1:0] m);
    int unsigned rate_bits [4] = '{1344, 1088, 1088, 576};
    return rate_bits[m] / 64;
  endfunction

  function automatic logic [Rate-1:0] rand_block();
    logic [Rate-1:0] b;
    for (int i = 0; i < Rate / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Build the blocks of one request and queue the words it must produce
  task automatic plan_request(input logic [1:0] m0, input int unsigned len, input bit mix);
    int unsigned     rem;
    int unsigned     nw;
    logic [1:0]      m;
    logic [Rate-1:0] b;
    plan_blk.delete();
    plan_mode.delete();
    if (m0 == 2'b10)      rem = 256 / 64;
    else if (m0 == 2'b11) rem = 512 / 64;
    else                  rem = (len == 0) ? 1 : len;
    m = m0;
    while (rem > 0) begin
      b  = rand_block();
      nw = (rem < wpb(m)) ? rem : wpb(m);
      for (int k = 0; k < int'(nw); k++) begin
        exp_q.push_back('{data: b[k*64 +: 64], last: (rem == 1)});
        rem--;
      end
      plan_blk.push_back(b);
      plan_mode.push_back(m);
      if (mix) m = 2'($urandom_range(0, 1));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic write_block(input logic [Rate-1:0] b, input logic [1:0] m,
                             input logic [31:0] len);
    int unsigned t  = 0;
    bit          ok = 1'b0;
    block_in       = b;
    operation_mode = m;
    out_len_in     = len;
    block_we_in    = 1'b1;
    while (!ok && t < 5000) begin
      @(negedge clk);
      if (block_ready_out) ok = 1'b1;
      t++;
    end
    @(posedge clk);
    #1;
    block_we_in = 1'b0;
    if (!ok) fail_now("write_timeout");
  endtask

  task automatic wait_drain();
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
      n_tests++;
      n_fail++;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_request(input logic [1:0] m0, input int unsigned len, input bit mix);
    plan_request(m0, len, mix);
    for (int i = 0; i < plan_blk.size(); i++) write_block(plan_blk[i], plan_mode[i], len);
    wait_drain();
  endtask

  always begin
    @(posedge clk);
    #1;
    if (rnd_ready) ready_in = 1'($urandom_range(0, 1));
  end

  // Monitor: compares every presented word with the scoreboard head
  exp_t mon_e;
  bit   prev_stall = 1'b0;
  bit   done_exp   = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      chk("req_done", 64'(req_done_out), 64'(done_exp));
      done_exp = 1'b0;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_word: got %h expected no word", data_out);
          n_tests++;
          n_fail++;
        end else begin
          mon_e = exp_q[0];
          chk("data", data_out, mon_e.data);
          chk("last", 64'(last_out), 64'(mon_e.last));
          if (ready_in) begin
            void'(exp_q.pop_front());
            done_exp = mon_e.last;
          end
        end
      end else begin
        if (prev_stall) fail_now("valid_dropped_without_handshake");
        chk("idle_data", data_out, 64'd0);
        chk("idle_last", 64'(last_out), 64'd0);
      end
      prev_stall = valid_out && !ready_in;
    end
  end

  initial begin
    logic [1:0] m;
    // Reset state
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_last", 64'(last_out), 64'd0);
    chk("rst_done", 64'(req_done_out), 64'd0);
    chk("rst_ready", 64'(block_ready_out), 64'd1);
    @(posedge clk);
    #1;

    // Directed requests with ready_in held high
    ready_in = 1'b1;
    do_request(2'b00, 30, 1'b0);
    do_request(2'b10, 99, 1'b0);
    do_request(2'b01, 0, 1'b0);
    do_request(2'b11, 5, 1'b0);

    // Full FIFO: third back-to-back write must be ignored
    ready_in = 1'b0;
    plan_request(2'b00, 60, 1'b0);
    write_block(plan_blk[0], 2'b00, 60);
    write_block(plan_blk[1], 2'b00, 60);
    block_in    = rand_block();
    block_we_in = 1'b1;
    @(negedge clk);
    chk("full_ready", 64'(block_ready_out), 64'd0);
    @(posedge clk);
    #1;
    block_we_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("full_ready_hold", 64'(block_ready_out), 64'd0);
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    write_block(plan_blk[2], 2'b00, 60);
    wait_drain();

    // Randomised requests under random backpressure
    rnd_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      m = 2'($urandom_range(0, 3));
      do_request(m, $urandom_range(0, 60), (m < 2'b10));
    end

    // Reset mid-stream aborts the request with no done pulse
    plan_request(2'b00, 40, 1'b0);
    write_block(plan_blk[0], 2'b00, 40);
    write_block(plan_blk[1], 2'b00, 40);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    rnd_ready = 1'b0;
    ready_in  = 1'b0;
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_data", data_out, 64'd0);
    chk("midrst_last", 64'(last_out), 64'd0);
    chk("midrst_done", 64'(req_done_out), 64'd0);
    chk("midrst_ready", 64'(block_ready_out), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 64'(valid_out), 64'd0);
    @(posedge clk);
    #1;

    // Single-word SHAKE256 request stalled for five cycles
    plan_request(2'b01, 0, 1'b0);
    write_block(plan_blk[0], 2'b01, 0);
    repeat (5) @(posedge clk);
    #1;
    ready_in = 1'b1;
    wait_drain();
`ifdef SQUEEZE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt_out), 64'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
